gate_resp_checker: RTL and testbench

//   Synthesizable response checker for 1-output logic-gate DUTs: the receiving end of gate

---
 rtl/gate_resp_checker.sv | 151 +++++++++++++++
 tb/tb_gate_resp_checker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_resp_checker.sv
// rtl/gate_resp_checker.sv - response checker for single-output logic-gate DUTs
module gate_resp_checker #(
    parameter int N_IN    = 2,
    parameter int GATE_OP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [N_IN-1:0]  vec_in,
    input  logic             obs_f,
    input  logic             vec_last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             cov_full,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid
);

    localparam int ROWS = 1 << N_IN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]  ff_vec_q, ff_vec_d;
    logic             ff_valid_q, ff_valid_d;
    logic [ROWS-1:0]  cov_q, cov_d;
    logic             pass_q, pass_d;

    logic             expected;
    logic             mismatch;
    logic             accept;
    logic             begin_run;
    logic [ROWS-1:0]  row_hit;

    // Golden gate function reduced over the stimulus vector
    always_comb begin
        expected = 1'b0;
        case (GATE_OP)
            0:       expected = &vec_in;
            1:       expected = |vec_in;
            2:       expected = ^vec_in;
            3:       expected = ~(&vec_in);
            4:       expected = ~(|vec_in);
            5:       expected = ~(^vec_in);
            default: expected = 1'b0;
        endcase
    end

    assign mismatch  = obs_f != expected;
    assign accept    = (state_q == S_RUN) && vec_valid;
    assign begin_run = (state_q != S_RUN) && start;
    assign row_hit   = {{(ROWS-1){1'b0}}, 1'b1} << vec_in;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start launches a run from IDLE/DONE; an accepted last beat ends it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (vec_valid && vec_last) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        vec_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_RUN:   begin vec_ready = 1'b1; busy = 1'b1; end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Result datapath: clear on run start, accumulate per accepted beat, verdict on last
    always_comb begin
        vec_cnt_d  = vec_cnt_q;
        err_cnt_d  = err_cnt_q;
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        cov_d      = cov_q;
        pass_d     = pass_q;
        if (begin_run) begin
            vec_cnt_d  = '0;
            err_cnt_d  = '0;
            ff_vec_d   = '0;
            ff_valid_d = 1'b0;
            cov_d      = '0;
            pass_d     = 1'b0;
        end else if (accept) begin
            if (vec_cnt_q != {CNT_W{1'b1}}) vec_cnt_d = vec_cnt_q + CNT_W'(1);
            if (mismatch && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (mismatch && !ff_valid_q) begin
                ff_vec_d   = vec_in;
                ff_valid_d = 1'b1;
            end
            cov_d = cov_q | row_hit;
            if (vec_last) pass_d = (err_cnt_d == '0) && (&cov_d);
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
            cov_q      <= '0;
            pass_q     <= 1'b0;
        end else begin
            vec_cnt_q  <= vec_cnt_d;
            err_cnt_q  <= err_cnt_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
            cov_q      <= cov_d;
            pass_q     <= pass_d;
        end
    end

    assign pass             = pass_q;
    assign cov_full         = &cov_q;
    assign vec_cnt          = vec_cnt_q;
    assign err_cnt          = err_cnt_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// tb/tb_gate_resp_checker.sv - table, directed and random checks of gate_resp_checker
module tb_gate_resp_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic [1:0] vec_in = 2'b00;
    logic       obs_f = 1'b0;
    logic       vec_last = 1'b0;

    // u_or: OR, 8-bit counters; u_sat: OR, 2-bit counters; u_xor: XOR, 8-bit counters
    logic       o_rdy, o_busy, o_done, o_pass, o_cov, o_ffv;
    logic [7:0] o_vc, o_ec;
    logic [1:0] o_ffvec;
    logic       s_rdy, s_busy, s_done, s_pass, s_cov, s_ffv;
    logic [1:0] s_vc, s_ec;
    logic [1:0] s_ffvec;
    logic       x_rdy, x_busy, x_done, x_pass, x_cov, x_ffv;
    logic [7:0] x_vc, x_ec;
    logic [1:0] x_ffvec;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gate_resp_checker #(.N_IN(2), .GATE_OP(1), .CNT_W(8)) u_or (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_ready(o_rdy),
        .vec_in(vec_in), .obs_f(obs_f), .vec_last(vec_last), .busy(o_busy), .done(o_done),
        .pass(o_pass), .cov_full(o_cov), .vec_cnt(o_vc), .err_cnt(o_ec),
        .first_fail_vec(o_ffvec), .first_fail_valid(o_ffv));

    gate_resp_checker #(.N_IN(2), .GATE_OP(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_ready(s_rdy),
        .vec_in(vec_in), .obs_f(obs_f), .vec_last(vec_last), .busy(s_busy), .done(s_done),
        .pass(s_pass), .cov_full(s_cov), .vec_cnt(s_vc), .err_cnt(s_ec),
        .first_fail_vec(s_ffvec), .first_fail_valid(s_ffv));

    gate_resp_checker #(.N_IN(2), .GATE_OP(2), .CNT_W(8)) u_xor (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_ready(x_rdy),
        .vec_in(vec_in), .obs_f(obs_f), .vec_last(vec_last), .busy(x_busy), .done(x_done),
        .pass(x_pass), .cov_full(x_cov), .vec_cnt(x_vc), .err_cnt(x_ec),
        .first_fail_vec(x_ffvec), .first_fail_valid(x_ffv));

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        vec_valid = 1'b0;
        vec_last = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_beat(input logic [1:0] v, input logic o, input logic l);
        @(negedge clk);
        vec_in = v;
        obs_f = o;
        vec_last = l;
        vec_valid = 1'b1;
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        vec_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // Reference: gate output from the count of ones in the vector
    function automatic logic ref_out(input int op, input logic [1:0] v);
        int ones;
        ones = int'(v[0]) + int'(v[1]);
        case (op)
            0: return ones == 2;
            1: return ones > 0;
            2: return (ones % 2) == 1;
            3: return ones != 2;
            4: return ones == 0;
            default: return (ones % 2) == 0;
        endcase
    endfunction

    typedef struct {
        bit       st;
        bit [1:0] v;
        bit       o;
        bit       l;
        int       vc;
        int       ec;
        bit       ffv;
        int       ffvec;
        bit       dn;
        bit       ps;
        bit       cv;
    } row_t;

    row_t tbl[14];

    initial begin
        logic [1:0] rv[$];
        logic       ro[$];
        int         ops[3];
        int         cmax[3];

        // st, vec, obs, last | vec_cnt, err_cnt, ffv, ffvec, done, pass, cov_full
        tbl[0]  = '{1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 2'b01, 1, 0, 2, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 2'b10, 1, 0, 3, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 2'b11, 1, 1, 4, 0, 0, 0, 1, 1, 1};
        tbl[4]  = '{1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 2'b01, 0, 0, 2, 1, 1, 1, 0, 0, 0};
        tbl[6]  = '{0, 2'b10, 0, 0, 3, 2, 1, 1, 0, 0, 0};
        tbl[7]  = '{0, 2'b11, 0, 1, 4, 3, 1, 1, 1, 0, 1};
        tbl[8]  = '{1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 2'b01, 1, 1, 2, 0, 0, 0, 1, 0, 0};
        tbl[10] = '{1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 2'b01, 1, 0, 2, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 2'b10, 1, 0, 3, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 2'b11, 1, 1, 4, 0, 0, 0, 1, 1, 1};
        ops  = '{1, 1, 2};
        cmax = '{255, 3, 255};

        // Reset state
        #12;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_ready", o_rdy, 0);
        chk("rst_pass", o_pass, 0);
        chk("rst_cov", o_cov, 0);
        chk("rst_vcnt", o_vc, 0);
        chk("rst_ecnt", o_ec, 0);
        chk("rst_ffv", o_ffv, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: OR pass, stuck-at-0, partial coverage, rerun after failure
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].st) begin
                do_start();
                chk($sformatf("t%0d_start_vcnt", i), o_vc, 0);
                chk($sformatf("t%0d_start_ecnt", i), o_ec, 0);
                chk($sformatf("t%0d_start_ffv", i), o_ffv, 0);
                chk($sformatf("t%0d_start_pass", i), o_pass, 0);
                chk($sformatf("t%0d_start_busy", i), o_busy, 1);
            end
            do_beat(tbl[i].v, tbl[i].o, tbl[i].l);
            chk($sformatf("t%0d_vcnt", i), o_vc, tbl[i].vc);
            chk($sformatf("t%0d_ecnt", i), o_ec, tbl[i].ec);
            chk($sformatf("t%0d_ffv", i), o_ffv, tbl[i].ffv);
            if (tbl[i].ffv) chk($sformatf("t%0d_ffvec", i), o_ffvec, tbl[i].ffvec);
            chk($sformatf("t%0d_done", i), o_done, tbl[i].dn);
            chk($sformatf("t%0d_busy", i), o_busy, !tbl[i].dn);
            chk($sformatf("t%0d_pass", i), o_pass, tbl[i].ps);
            chk($sformatf("t%0d_cov", i), o_cov, tbl[i].cv);
        end

        // DONE holds and ignores vec_valid
        @(negedge clk);
        vec_valid = 1'b1;
        vec_in = 2'b00;
        obs_f = 1'b1;
        idle(3);
        vec_valid = 1'b0;
        chk("done_hold_vcnt", o_vc, 4);
        chk("done_hold_ecnt", o_ec, 0);
        chk("done_hold_done", o_done, 1);
        chk("done_hold_pass", o_pass, 1);

        // Saturation: six mismatching OR beats on 2-bit counters
        do_start();
        for (int i = 0; i < 6; i++) do_beat(2'(i), (i % 4) == 0, i == 5);
        chk("sat_ecnt", s_ec, 3);
        chk("sat_vcnt", s_vc, 3);
        chk("sat_pass", s_pass, 0);
        chk("sat_done", s_done, 1);
        chk("sat_wide_ecnt", o_ec, 6);

        // Start held with valid in the start cycle accepts nothing; mid-RUN start ignored
        @(negedge clk);
        start = 1'b1;
        vec_valid = 1'b1;
        vec_in = 2'b01;
        obs_f = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        vec_valid = 1'b0;
        chk("startcyc_vcnt", o_vc, 0);
        do_beat(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        vec_valid = 1'b1;
        vec_in = 2'b01;
        obs_f = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        vec_valid = 1'b0;
        chk("midrun_start_vcnt", o_vc, 2);
        chk("midrun_start_busy", o_busy, 1);

        // Asynchronous reset mid-run, then vec_valid in IDLE is ignored
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_vcnt", o_vc, 0);
        chk("arst_ecnt", o_ec, 0);
        chk("arst_done", o_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        vec_valid = 1'b1;
        obs_f = 1'b0;
        idle(3);
        vec_valid = 1'b0;
        chk("idle_valid_vcnt", o_vc, 0);
        chk("idle_valid_busy", o_busy, 0);

        // XOR checker passes a correct XOR truth table
        do_start();
        do_beat(2'b00, 1'b0, 1'b0);
        do_beat(2'b01, 1'b1, 1'b0);
        do_beat(2'b10, 1'b1, 1'b0);
        do_beat(2'b11, 1'b0, 1'b1);
        chk("xor_done", x_done, 1);
        chk("xor_pass", x_pass, 1);
        chk("xor_ecnt", x_ec, 0);
        chk("xor_cov", x_cov, 1);

        // Random runs against the reference model for all three checkers
        for (int r = 0; r < 40; r++) begin
            int len;
            int pick;
            rv.delete();
            ro.delete();
            len = int'($urandom_range(1, 8));
            pick = int'($urandom_range(0, 2));
            for (int b = 0; b < len; b++) begin
                logic [1:0] v;
                v = 2'($urandom_range(0, 3));
                rv.push_back(v);
                ro.push_back(ref_out(ops[pick], v) ^ ($urandom_range(0, 3) == 0));
            end
            do_start();
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
                do_beat(rv[b], ro[b], b == len - 1);
            end
            for (int k = 0; k < 3; k++) begin
                int  mis;
                int  ffv;
                int  ffvec;
                bit  seen[4];
                bit  full;
                int  exp_vc;
                int  exp_ec;
                int  a_vc, a_ec, a_ffv, a_ffvec, a_dn, a_ps, a_cv;
                mis = 0;
                ffv = 0;
                ffvec = 0;
                seen = '{0, 0, 0, 0};
                foreach (rv[b]) begin
                    seen[rv[b]] = 1'b1;
                    if (ro[b] != ref_out(ops[k], rv[b])) begin
                        if (ffv == 0) ffvec = int'(rv[b]);
                        ffv = 1;
                        mis++;
                    end
                end
                full = seen[0] && seen[1] && seen[2] && seen[3];
                exp_vc = (len > cmax[k]) ? cmax[k] : len;
                exp_ec = (mis > cmax[k]) ? cmax[k] : mis;
                case (k)
                    0: begin a_vc = o_vc; a_ec = o_ec; a_ffv = o_ffv; a_ffvec = o_ffvec;
                             a_dn = o_done; a_ps = o_pass; a_cv = o_cov; end
                    1: begin a_vc = s_vc; a_ec = s_ec; a_ffv = s_ffv; a_ffvec = s_ffvec;
                             a_dn = s_done; a_ps = s_pass; a_cv = s_cov; end
                    default: begin a_vc = x_vc; a_ec = x_ec; a_ffv = x_ffv; a_ffvec = x_ffvec;
                             a_dn = x_done; a_ps = x_pass; a_cv = x_cov; end
                endcase
                chk($sformatf("rnd%0d_dut%0d_vcnt", r, k), a_vc, exp_vc);
                chk($sformatf("rnd%0d_dut%0d_ecnt", r, k), a_ec, exp_ec);
                chk($sformatf("rnd%0d_dut%0d_ffv", r, k), a_ffv, ffv);
                if (ffv != 0) chk($sformatf("rnd%0d_dut%0d_ffvec", r, k), a_ffvec, ffvec);
                chk($sformatf("rnd%0d_dut%0d_done", r, k), a_dn, 1);
                chk($sformatf("rnd%0d_dut%0d_cov", r, k), a_cv, int'(full));
                chk($sformatf("rnd%0d_dut%0d_pass", r, k), a_ps, int'(full && mis == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
